// File: rtl/lock_display_scan_pkg.sv
// lock_pkg: shared constants and types for the door-lock display scanner.
//   Digit codes   : CODE_DASH, CODE_BLANK
//   Segment words : SEG_OFF, SEG_DASH ({g,f,e,d,c,b,a}, active-low)
//   Types         : didx_t (digit index), blink_ph_e (blink half-period),
//                   frame_t (one latched frame: flags plus four digit codes)
package lock_pkg;

    localparam logic [3:0] CODE_DASH  = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    typedef logic [1:0] didx_t;

    typedef enum logic {
        PH_SHOW = 1'b0,
        PH_HIDE = 1'b1
    } blink_ph_e;

    typedef struct packed {
        logic        alert;
        logic        unlock;
        logic [15:0] digits;
    } frame_t;

endpackage

// File: rtl/lock_display_scan_if.sv
// lock_display_scan_if: bundle between the lock controller and the display
// scanner.
//   DISPLAY[15:0] : four digit codes, [3:0] = rightmost digit
//   ALERT, UNLOCK : level flags shown as blink / decimal point
//   SEG_N[6:0]    : {g,f,e,d,c,b,a}, active-low
//   DP_N          : decimal point, active-low
//   DIG_N[3:0]    : digit enables, active-low
// master = lock controller side, slave = scanner side.
interface lock_display_scan_if;

    logic [15:0] DISPLAY;
    logic        ALERT;
    logic        UNLOCK;
    logic [6:0]  SEG_N;
    logic        DP_N;
    logic [3:0]  DIG_N;

    modport master (
        output DISPLAY, ALERT, UNLOCK,
        input  SEG_N, DP_N, DIG_N
    );

    modport slave (
        input  DISPLAY, ALERT, UNLOCK,
        output SEG_N, DP_N, DIG_N
    );

endinterface

// File: rtl/lock_display_scan_seg7_decode.sv
// seg7_decode: combinational digit-code to seven-segment decoder.
//   code_i[3:0]  : 0-9 numerals, A-D letters, E dash, F blank
//   seg_n_o[6:0] : {g,f,e,d,c,b,a}, active-low
module seg7_decode
    import lock_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_OFF;
        case (code_i)
            4'h0:       seg_n_o = 7'h40;
            4'h1:       seg_n_o = 7'h79;
            4'h2:       seg_n_o = 7'h24;
            4'h3:       seg_n_o = 7'h30;
            4'h4:       seg_n_o = 7'h19;
            4'h5:       seg_n_o = 7'h12;
            4'h6:       seg_n_o = 7'h02;
            4'h7:       seg_n_o = 7'h78;
            4'h8:       seg_n_o = 7'h00;
            4'h9:       seg_n_o = 7'h10;
            4'hA:       seg_n_o = 7'h08;
            4'hB:       seg_n_o = 7'h03;
            4'hC:       seg_n_o = 7'h46;
            4'hD:       seg_n_o = 7'h21;
            CODE_DASH:  seg_n_o = SEG_DASH;
            CODE_BLANK: seg_n_o = SEG_OFF;
            default:    seg_n_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/lock_display_scan.sv
// lock_display_scan: multiplexed 4-digit seven-segment driver.
//   CLK, RESET : system clock, synchronous active-high reset
//   bus        : slave side of lock_display_scan_if (DISPLAY/ALERT/UNLOCK in,
//                SEG_N/DP_N/DIG_N out, all outputs registered)
// Parameters:
//   SCAN_DIV     : clock cycles per digit slot (>= 4)
//   BLINK_FRAMES : frames per blink half-period (>= 1)
module lock_display_scan
    import lock_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                CLK,
    input  logic                RESET,
    lock_display_scan_if.slave  bus
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);
    localparam frame_t FRAME_RST = '{alert: 1'b0, unlock: 1'b0, digits: 16'hFFFF};

    logic [PW-1:0] pcnt_q, pcnt_d;
    didx_t         didx_q, didx_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    blink_ph_e     blink_ph_q, blink_ph_d;
    frame_t        frame_q, frame_d;

    logic [6:0] seg_n_q, seg_n_d;
    logic       dp_n_q, dp_n_d;
    logic [3:0] dig_n_q, dig_n_d;

    logic       slot_wrap;
    logic       frame_wrap;
    logic       blanked;
    logic [3:0] cur_code;
    logic [6:0] cur_seg;

    seg7_decode u_decode (
        .code_i  (cur_code),
        .seg_n_o (cur_seg)
    );

    always_comb begin
        slot_wrap  = (pcnt_q == PCNT_LAST);
        frame_wrap = slot_wrap && (didx_q == 2'd3);

        pcnt_d     = slot_wrap ? '0 : pcnt_q + PW'(1);
        didx_d     = slot_wrap ? didx_q + 2'd1 : didx_q;
        frame_d    = frame_q;
        fcnt_d     = fcnt_q;
        blink_ph_d = blink_ph_q;

        if (frame_wrap) begin
            frame_d = '{alert: bus.ALERT, unlock: bus.UNLOCK, digits: bus.DISPLAY};
            // Counting only starts once a frame has actually been shown under
            // alert, so a fresh alert always opens with a visible half-period.
            if (!bus.ALERT || !frame_q.alert) begin
                fcnt_d     = '0;
                blink_ph_d = PH_SHOW;
            end else if (fcnt_q == FCNT_LAST) begin
                fcnt_d     = '0;
                blink_ph_d = (blink_ph_q == PH_SHOW) ? PH_HIDE : PH_SHOW;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    always_comb begin
        cur_code = frame_q.digits[{didx_q, 2'b00} +: 4];
        blanked  = frame_q.alert && (blink_ph_q == PH_HIDE);
        seg_n_d  = blanked ? SEG_OFF : cur_seg;
        dp_n_d   = !((didx_q == 2'd0) && frame_q.unlock && !blanked);
        // First cycle of every slot keeps all digits dark so the segment bus
        // can settle to the next digit without ghosting.
        dig_n_d  = (pcnt_q == '0) ? 4'hF : ~(4'b0001 << didx_q);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pcnt_q     <= '0;
            didx_q     <= '0;
            fcnt_q     <= '0;
            blink_ph_q <= PH_SHOW;
            frame_q    <= FRAME_RST;
            seg_n_q    <= SEG_OFF;
            dp_n_q     <= 1'b1;
            dig_n_q    <= 4'hF;
        end else begin
            pcnt_q     <= pcnt_d;
            didx_q     <= didx_d;
            fcnt_q     <= fcnt_d;
            blink_ph_q <= blink_ph_d;
            frame_q    <= frame_d;
            seg_n_q    <= seg_n_d;
            dp_n_q     <= dp_n_d;
            dig_n_q    <= dig_n_d;
        end
    end

    assign bus.SEG_N = seg_n_q;
    assign bus.DP_N  = dp_n_q;
    assign bus.DIG_N = dig_n_q;

    always @(posedge CLK) begin
        assert (SCAN_DIV >= 4 && BLINK_FRAMES >= 1)
            else $error("lock_display_scan: illegal SCAN_DIV=%0d or BLINK_FRAMES=%0d",
                        SCAN_DIV, BLINK_FRAMES);
    end

endmodule

// File: doc/lock_display_scan.md
# lock_display_scan

Multiplexed 4-digit seven-segment driver for the door-lock controller. Consumes the lock's `DISPLAY[15:0]` word (four 4-bit digit codes), `ALERT` and `UNLOCK`, and time-multiplexes them onto one common segment bus with per-digit enables. It sits between `TOP` and the board pins.

## Interface
- `SCAN_DIV`, default 1000: clock cycles per digit slot; legal range is 4 or more.
- `BLINK_FRAMES`, default 64: full 4-digit frames per half-period of the alert blink; legal range is 1 or more.
- `CLK  in  1`: system clock.
- `RESET  in  1`: synchronous, active-high reset.
- `DISPLAY  in  16`: four digit codes; `[3:0]` is digit 0 (rightmost) and `[15:12]` is digit 3.
- `ALERT  in  1`: level input; while high, all digits blink.
- `UNLOCK  in  1`: level input; while high, the decimal point of digit 0 is lit.
- `SEG_N  out  7`: `{g,f,e,d,c,b,a}`, active-low.
- `DP_N  out  1`: decimal point, active-low.
- `DIG_N  out  4`: digit enables, active-low, one-hot-low when active.

## Operation
- Digit code map:
  - 0–9: numerals.
  - 0xA–0xD: A, b, C, d.
  - 0xE: dash, g only.
  - 0xF: blank.
- Required `SEG_N` values:
  - 0 → 0x40
  - 1 → 0x79
  - 8 → 0x00
  - 0xE → 0x3F
  - 0xF → 0x7F
- Prescaler `pcnt` counts 0..SCAN_DIV-1 and wraps. At wrap, digit index `didx` advances 0→1→2→3→0.
- Frame latch: `frame_q` captures `DISPLAY` in the cycle where `didx` wraps 3→0. Digits shown within one frame always come from a single snapshot, so there is no tearing.
- Anti-ghosting: while `pcnt == 0`, `DIG_N` = 0xF. For `pcnt` 1..SCAN_DIV-1, `DIG_N[didx]` is 0 and the others are 1.
- `SEG_N` = decode(`frame_q[4*didx +: 4]`).
- `DP_N` = 0 only when `didx == 0`, the latched UNLOCK snapshot is 1, and the digit is not blanked by blink.
- Blink:
  - Frame counter `fcnt` counts 0..BLINK_FRAMES-1 on each frame wrap.
  - `blink_ph` toggles when `fcnt` wraps.
  - While latched ALERT = 1 and `blink_ph` = 1, force `SEG_N` = 0x7F and `DP_N` = 1. `DIG_N` keeps scanning.
  - While ALERT = 0, `blink_ph` is held at 0 and `fcnt` at 0. Blink therefore always begins with a visible half-period.
- ALERT and UNLOCK are latched together with `DISPLAY` at the frame boundary.

## Timing
- All outputs are registered and update one cycle after the internal state changes.
- Reset values, applied on the clock edge where RESET = 1:
  - `SEG_N` = 0x7F, `DP_N` = 1, `DIG_N` = 0xF.
  - `pcnt` = 0, `didx` = 0, `fcnt` = 0, `blink_ph` = 0.
  - `frame_q` = 0xFFFF; latched ALERT = 0; latched UNLOCK = 0.
- First frame after reset: frame latch occurs at the end of the first 3→0 wrap, so the first frame shows blanks. Worst-case latency from a `DISPLAY` change to visible output is 8*SCAN_DIV+1 cycles.
- Reset asserted mid-frame: all state returns to reset values on that edge, with no partial-frame output afterwards.
- `DISPLAY` changing in the same cycle as the latch edge: the new value is captured.
- Simultaneous ALERT rise and frame wrap: ALERT is latched, and `blink_ph` starts at 0.
- Invalid parameters are caught by a simulation-time assertion; no hardware handling is required.

## Structure
- Package `lock_pkg`:
  - Digit code localparams: `CODE_DASH` = 4'hE, `CODE_BLANK` = 4'hF.
  - Segment constants: `SEG_OFF` = 7'h7F, `SEG_DASH` = 7'h3F.
  - Digit-index type, 2 bits.
- Sub-module `seg7_decode`: purely combinational, 4-bit code in, 7-bit active-low segments out. It is instantiated once on the muxed digit.
- Top module: prescaler, digit counter, frame latch, blink counter, output registers. Expected size is about 150–200 lines.

## Test plan
Bench parameters: SCAN_DIV = 4, BLINK_FRAMES = 2. CLK period is 50 ns.

1. **Reset.** Hold RESET for 4 cycles with `DISPLAY` = 0x1234. Required: `SEG_N` = 0x7F, `DIG_N` = 0xF, `DP_N` = 1 throughout. After release, the first 16 cycles show only `SEG_N` = 0x7F.
2. **Scan order.** `DISPLAY` = 0x8E10 held. In the second frame:
   - Digit 0 shows 0x40 with `DIG_N` = 0xE, active for 3 of every 4 cycles.
   - Then digit 1 shows 0x79 (`DIG_N` 0xD), digit 2 shows 0x3F (`DIG_N` 0xB), digit 3 shows 0x00 (`DIG_N` 0x7).
   - `DIG_N` = 0xF on every slot's first cycle.
3. **Tear-free update.** Change `DISPLAY` from 0x1111 to 0x0000 mid-frame while digit 2 is active. Required: digits 2–3 still show 0x79 for the rest of that frame, and the next frame shows all 0x40.
4. **Unlock.** Set UNLOCK = 1 with `DISPLAY` = 0xFFF0. Required: from the next frame, `DP_N` = 0 only during digit-0 active cycles.
5. **Alert blink.** Set ALERT = 1 with `DISPLAY` = 0x8888. Required: 2 frames showing 0x00, then 2 frames of `SEG_N` = 0x7F with `DIG_N` still scanning, repeating. When ALERT falls, the next frame is visible.
6. **Mid-operation reset.** Pulse RESET for 1 cycle during digit 2 of scenario 5. Required: outputs return to their reset values on the next edge, and blink restarts in the visible phase.
